fcmp_arbiter: RTL and testbench

Shares one FP compare datapath (feq/flt/fle) between NREQ requesters, e.g. the integer-pipe issue slot and the FP-pipe issue slot. Each requester uses a valid/ready handshake. A round-robin grant selects one request per cycle. The result is registered in a one-entry output stage with its own valid/ready handshake, and returns to writeback tagged with destination register and source index.

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fcmp_core.sv | 37 +++
 rtl/fcmp_arbiter.sv | 86 ++++++++
 tb/tb_fcmp_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP compare path.
package fpu_pkg;

  localparam int FP_W = 32;

  typedef enum logic [1:0] {
    FEQ  = 2'b00,
    FLT  = 2'b01,
    FLE  = 2'b10,
    FRSV = 2'b11
  } fcmp_op_e;

endpackage

// File: rtl/fcmp_core.sv
// Combinational binary32 compare (feq/flt/fle), no NaN handling; +0 and -0 compare equal.
module fcmp_core
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] x,
  input  logic [FP_W-1:0] y,
  input  fcmp_op_e        op,
  output logic [FP_W-1:0] z
);

  logic both_zero, feq, fle, flt, mag_le, mag_ge, bit_z;

  assign both_zero = ~|x[30:0] & ~|y[30:0];
  assign feq       = (x == y) | both_zero;
  assign mag_le    = x[30:0] <= y[30:0];
  assign mag_ge    = x[30:0] >= y[30:0];

  // sign/magnitude ordering: for two negatives the larger magnitude is the smaller value
  assign fle = both_zero
             | (x[31] & ~y[31])
             | (~x[31] & ~y[31] & mag_le)
             | (x[31] & y[31] & mag_ge);
  assign flt = fle & ~feq;

  always_comb begin
    bit_z = 1'b0;
    case (op)
      FEQ:     bit_z = feq;
      FLT:     bit_z = flt;
      FLE:     bit_z = fle;
      default: bit_z = 1'b0;
    endcase
  end

  assign z = {{(FP_W-1){1'b0}}, bit_z};

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin sharing of one fcmp_core between NREQ requesters, with a one-entry
// registered result stage under valid/ready flow control.
module fcmp_arbiter
  import fpu_pkg::*;
#(
  parameter int  NREQ = 2,
  parameter int  TAGW = 6,
  localparam int SRCW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*2-1:0]    req_op,
  input  logic [NREQ*FP_W-1:0] req_x,
  input  logic [NREQ*FP_W-1:0] req_y,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [FP_W-1:0]      res_z,
  output logic [TAGW-1:0]      res_tag,
  output logic [SRCW-1:0]      res_src
);

  logic [SRCW-1:0] last;
  logic [SRCW-1:0] gidx;
  logic [SRCW-1:0] idx;
  logic [NREQ-1:0] gnt;
  logic            found;
  logic            can_accept;
  logic            xfer;
  logic [FP_W-1:0] sel_x, sel_y, core_z;
  logic [TAGW-1:0] sel_tag;
  fcmp_op_e        sel_op;

  // scan starts one past the last winner; NREQ is a power of two so the add wraps for free
  always_comb begin
    gnt   = '0;
    gidx  = last;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = last + SRCW'(k);
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        gidx      = idx;
        gnt[idx]  = 1'b1;
      end
    end
  end

  assign can_accept = ~res_valid | res_ready;
  assign req_ready  = gnt & {NREQ{can_accept & rstn}};
  assign xfer       = found & can_accept;

  assign sel_x   = req_x[FP_W*int'(gidx) +: FP_W];
  assign sel_y   = req_y[FP_W*int'(gidx) +: FP_W];
  assign sel_tag = req_tag[TAGW*int'(gidx) +: TAGW];
  assign sel_op  = fcmp_op_e'(req_op[2*int'(gidx) +: 2]);

  fcmp_core u_core (
    .x  (sel_x),
    .y  (sel_y),
    .op (sel_op),
    .z  (core_z)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_valid <= 1'b0;
      res_z     <= '0;
      res_tag   <= '0;
      res_src   <= '0;
      last      <= SRCW'(NREQ-1);
    end else if (xfer) begin
      res_valid <= 1'b1;
      res_z     <= core_z;
      res_tag   <= sel_tag;
      res_src   <= gidx;
      last      <= gidx;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Directed-vector bench for fcmp_arbiter with NREQ=2, TAGW=6.
module tb_fcmp_arbiter;

  localparam int NREQ = 2;
  localparam int TAGW = 6;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*2-1:0] req_op;
  logic [NREQ*32-1:0] req_x;
  logic [NREQ*32-1:0] req_y;
  logic [NREQ*TAGW-1:0] req_tag;
  logic              res_valid;
  logic              res_ready;
  logic [31:0]       res_z;
  logic [TAGW-1:0]   res_tag;
  logic [0:0]        res_src;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fcmp_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_tag   (req_tag),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .res_tag   (res_tag),
    .res_src   (res_src)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [TAGW-1:0] t);
    req_op[2*s +: 2]     = op;
    req_x[32*s +: 32]    = x;
    req_y[32*s +: 32]    = y;
    req_tag[TAGW*s +: TAGW] = t;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // single request from s; checks the handshake and the result one cycle later
  task automatic issue(input string name, input int s, input logic [1:0] op,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [TAGW-1:0] t, input logic [31:0] expz);
    req_valid    = '0;
    req_valid[s] = 1'b1;
    set_req(s, op, x, y, t);
    #1;
    check({name, "_ready"}, 32'(req_ready), 32'(1 << s));
    tick();
    req_valid = '0;
    check({name, "_valid"}, 32'(res_valid), 32'd1);
    check({name, "_z"}, res_z, expz);
    check({name, "_tag"}, 32'(res_tag), 32'(t));
    check({name, "_src"}, 32'(res_src), 32'(s));
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_x     = '0;
    req_y     = '0;
    req_tag   = '0;
    res_ready = 1'b1;
    #2;
    check("rst_valid", 32'(res_valid), 32'd0);
    check("rst_z", res_z, 32'd0);
    check("rst_tag", 32'(res_tag), 32'd0);
    check("rst_src", 32'(res_src), 32'd0);
    req_valid = 2'b11;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    tick();
    rstn = 1'b1;
    tick();

    issue("fle_1_2",   0, 2'b10, 32'h3F800000, 32'h40000000, 6'd5,  32'd1);
    issue("feq_m0_p0", 0, 2'b00, 32'h80000000, 32'h00000000, 6'd7,  32'd1);
    issue("flt_m0_p0", 0, 2'b01, 32'h80000000, 32'h00000000, 6'd8,  32'd0);
    issue("fle_m1_m1", 1, 2'b10, 32'hBF800000, 32'hBF800000, 6'd9,  32'd1);
    issue("flt_m1_p1", 1, 2'b01, 32'hBF800000, 32'h3F800000, 6'd11, 32'd1);
    issue("fle_2_1",   0, 2'b10, 32'h40000000, 32'h3F800000, 6'd12, 32'd0);
    issue("flt_m2_m1", 0, 2'b01, 32'hC0000000, 32'hBF800000, 6'd13, 32'd1);
    issue("feq_ulp",   1, 2'b00, 32'h3F800000, 32'h3F800001, 6'd14, 32'd0);

    // contention: last winner was 1, so order is 0,1,0,1
    set_req(0, 2'b00, 32'h3F800000, 32'h3F800000, 6'd10);
    set_req(1, 2'b01, 32'h40000000, 32'h3F800000, 6'd20);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_ready", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      check("cont_valid", 32'(res_valid), 32'd1);
      check("cont_src", 32'(res_src), 32'(i % 2));
      check("cont_z", res_z, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_tag", 32'(res_tag), (i % 2 == 0) ? 32'd10 : 32'd20);
    end

    // backpressure: result from requester 1 is held
    res_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(req_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(res_valid), 32'd1);
      check("bp_src", 32'(res_src), 32'd1);
      check("bp_tag", 32'(res_tag), 32'd20);
      check("bp_z", res_z, 32'd0);
    end
    res_ready = 1'b1;
    #1;
    check("bp_rel_ready", 32'(req_ready), 32'd1);
    tick();
    check("bp_rel_src", 32'(res_src), 32'd0);
    check("bp_rel_tag", 32'(res_tag), 32'd10);
    check("bp_rel_valid", 32'(res_valid), 32'd1);

    // asynchronous reset with a result held
    #2;
    rstn = 1'b0;
    #1;
    check("arst_valid", 32'(res_valid), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd0);
    tick();
    rstn = 1'b1;
    set_req(0, 2'b11, 32'h3F800000, 32'h3F800000, 6'd33);
    set_req(1, 2'b11, 32'h3F800000, 32'h3F800000, 6'd44);
    req_valid = 2'b11;
    #1;
    check("post_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = '0;
    check("rsv_valid", 32'(res_valid), 32'd1);
    check("rsv_z", res_z, 32'd0);
    check("rsv_src", 32'(res_src), 32'd0);
    check("rsv_tag", 32'(res_tag), 32'd33);
    tick();
    check("drain_valid", 32'(res_valid), 32'd0);
    check("drain_tag", 32'(res_tag), 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
